// File: rtl/sudoku_pkg.sv
// Shared types and constants for the game timer.
// Holds the timer state enum and default counter sizing.
package sudoku_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUNNING,
      PAUSED,
      FINISHED
   } timer_state_t;

   localparam int TIMER_W      = 12;
   localparam int TIMER_MAX    = 4095;
   localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/game_timer_if.sv
// Control/status bundle between button front-end and game timer.
// master: drives start/pause/stop pulses, reads time and status.
// slave : the timer; reads pulses, drives time and status.
interface game_timer_if #(
   parameter int TIMER_W = sudoku_pkg::TIMER_W
);
   logic               start;
   logic               pause;
   logic               stop;
   logic [TIMER_W-1:0] timer;
   logic [6:0]         minutes;
   logic [5:0]         seconds;
   logic               tick;
   logic               running;
   logic               finish;

   modport master (
      output start, pause, stop,
      input  timer, minutes, seconds, tick, running, finish
   );

   modport slave (
      input  start, pause, stop,
      output timer, minutes, seconds, tick, running, finish
   );
endinterface

// File: rtl/game_timer_tick_divider.sv
// Prescaler: counts 0..CLK_HZ-1 while en, pulses wrap on the last count.
// Ports: clk, rst (sync high), en, clr, wrap (combinational, internal use).
module tick_divider #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic wrap
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

   logic [PW-1:0] count;

   // When en is low the count holds, so a pause on the last count
   // leaves it at LAST and the wrap fires on the first enabled cycle.
   assign wrap = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end
endmodule

// File: rtl/game_timer.sv
// Elapsed game time: 1 Hz prescaler, start/pause/finish FSM,
// saturating seconds counter mirrored as minutes/seconds.
// Ports: clk_50MHz, rst (sync high), bus (game_timer_if.slave).
module game_timer #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int TIMER_W   = sudoku_pkg::TIMER_W,
   parameter int TIMER_MAX = sudoku_pkg::TIMER_MAX
) (
   input  logic         clk_50MHz,
   input  logic         rst,
   game_timer_if.slave  bus
);
   import sudoku_pkg::*;

   localparam logic [TIMER_W-1:0] PRE_MAX = TIMER_W'(TIMER_MAX - 1);
   localparam logic [5:0]         SEC_TOP = 6'(SECS_PER_MIN - 1);

   timer_state_t       state;
   logic [TIMER_W-1:0] timer;
   logic [6:0]         minutes;
   logic [5:0]         seconds;
   logic               tick;
   logic               running;
   logic               finish;

   logic launch;
   logic count_en;
   logic wrap;

   // Start only matters where a new game may begin.
   assign launch = bus.start &&
                   ((state == IDLE) || (state == FINISHED));

   // A stop or pause cycle does not count, so a wrap on that
   // cycle is discarded and the prescaler holds.
   assign count_en = (state == RUNNING) && !bus.pause && !bus.stop;

   tick_divider #(
      .CLK_HZ (CLK_HZ)
   ) u_div (
      .clk  (clk_50MHz),
      .rst  (rst),
      .en   (count_en),
      .clr  (launch),
      .wrap (wrap)
   );

   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         minutes <= '0;
         seconds <= '0;
         tick    <= 1'b0;
         running <= 1'b0;
         finish  <= 1'b0;
      end else begin
         tick <= 1'b0;
         unique case (state)
            IDLE, FINISHED: begin
               if (bus.start) begin
                  state   <= RUNNING;
                  timer   <= '0;
                  minutes <= '0;
                  seconds <= '0;
                  running <= 1'b1;
                  finish  <= 1'b0;
               end
            end
            RUNNING: begin
               priority case (1'b1)
                  bus.stop: begin
                     state   <= FINISHED;
                     running <= 1'b0;
                     finish  <= 1'b1;
                  end
                  bus.pause: begin
                     state   <= PAUSED;
                     running <= 1'b0;
                  end
                  wrap: begin
                     timer <= timer + 1'b1;
                     tick  <= 1'b1;
                     if (seconds == SEC_TOP) begin
                        seconds <= '0;
                        minutes <= minutes + 7'd1;
                     end else begin
                        seconds <= seconds + 6'd1;
                     end
                     // The increment reaching the max also ends the game.
                     if (timer == PRE_MAX) begin
                        state   <= FINISHED;
                        running <= 1'b0;
                        finish  <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            PAUSED: begin
               priority case (1'b1)
                  bus.stop: begin
                     state  <= FINISHED;
                     finish <= 1'b1;
                  end
                  bus.pause: begin
                     state   <= RUNNING;
                     running <= 1'b1;
                  end
                  default: ;
               endcase
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.timer   = timer;
   assign bus.minutes = minutes;
   assign bus.seconds = seconds;
   assign bus.tick    = tick;
   assign bus.running = running;
   assign bus.finish  = finish;
endmodule

// File: tb/tb_game_timer.sv
// Random + directed bench for game_timer with a scoreboard queue
// fed by a behavioural elapsed-time model.
module tb_game_timer;
   localparam int CLK_HZ = 10;
   localparam int TW     = 12;
   localparam int TMAX   = 75;

   logic clk = 1'b0;
   logic rst = 1'b1;

   game_timer_if #(.TIMER_W(TW)) bus ();

   game_timer #(
      .CLK_HZ    (CLK_HZ),
      .TIMER_W   (TW),
      .TIMER_MAX (TMAX)
   ) dut (
      .clk_50MHz (clk),
      .rst       (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      bit tick;
      bit run;
      bit fin;
   } exp_t;

   exp_t q[$];
   int vectors     = 0;
   int miscompares = 0;

   // Model: phase 0 idle, 1 running, 2 paused, 3 finished.
   // acc counts counted running cycles within the current second.
   int m_phase = 0;
   int m_t     = 0;
   int m_acc   = 0;
   bit m_tick  = 0;

   task automatic model(input bit r, input bit s,
                        input bit p, input bit x);
      if (r) begin
         m_phase = 0; m_t = 0; m_acc = 0; m_tick = 0;
      end else begin
         m_tick = 0;
         case (m_phase)
            0, 3: if (s) begin
               m_phase = 1; m_t = 0; m_acc = 0;
            end
            1: begin
               if (x) m_phase = 3;
               else if (p) m_phase = 2;
               else begin
                  m_acc++;
                  if (m_acc == CLK_HZ) begin
                     m_acc = 0;
                     m_t++;
                     m_tick = 1;
                     if (m_t == TMAX) m_phase = 3;
                  end
               end
            end
            2: begin
               if (x) m_phase = 3;
               else if (p) m_phase = 1;
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic step(input bit r, input bit s,
                       input bit p, input bit x);
      exp_t e;
      @(negedge clk);
      rst       = r;
      bus.start = s;
      bus.pause = p;
      bus.stop  = x;
      model(r, s, p, x);
      e.t    = m_t;
      e.tick = m_tick;
      e.run  = (m_phase == 1);
      e.fin  = (m_phase == 3);
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic run_until_t(input int target, input int budget);
      int n;
      n = 0;
      while (m_t != target && n < budget) begin
         step(0, 0, 0, 0);
         n++;
      end
      vectors++;
      if (m_t != target) begin
         miscompares++;
         $display("FAIL run_until_t: reached t=%0d, required %0d",
                  m_t, target);
      end
   endtask

   task automatic run_to_prewrap(input int budget);
      int n;
      n = 0;
      while (!(m_phase == 1 && m_acc == CLK_HZ - 1) && n < budget) begin
         step(0, 0, 0, 0);
         n++;
      end
      vectors++;
      if (!(m_phase == 1 && m_acc == CLK_HZ - 1)) begin
         miscompares++;
         $display("FAIL prewrap: phase=%0d acc=%0d, required 1/%0d",
                  m_phase, m_acc, CLK_HZ - 1);
      end
   endtask

   // Monitor: compares the outputs after every edge that has a
   // pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (bus.timer   !== TW'(e.t)        ||
                bus.minutes !== 7'(e.t / 60)    ||
                bus.seconds !== 6'(e.t % 60)    ||
                bus.tick    !== e.tick          ||
                bus.running !== e.run           ||
                bus.finish  !== e.fin) begin
               miscompares++;
               $display({"FAIL outputs @%0t: got t=%0d m=%0d s=%0d ",
                         "tick=%0b run=%0b fin=%0b, required ",
                         "t=%0d m=%0d s=%0d tick=%0b run=%0b fin=%0b"},
                        $time, bus.timer, bus.minutes, bus.seconds,
                        bus.tick, bus.running, bus.finish,
                        e.t, e.t / 60, e.t % 60, e.tick, e.run, e.fin);
            end
         end
      end
   end

   initial begin
      int r;
      bus.start = 1'b0;
      bus.pause = 1'b0;
      bus.stop  = 1'b0;

      // Reset, start, two seconds of counting.
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      idle(25);

      // Pause mid-second, hold, resume.
      idle(3);
      step(0, 0, 1, 0);
      idle(30);
      step(0, 0, 1, 0);
      idle(15);

      // Minute rollover, then stop and stay frozen.
      run_until_t(61, 1000);
      step(0, 0, 0, 1);
      idle(50);

      // Saturation at the maximum.
      step(0, 1, 0, 0);
      run_until_t(TMAX, 1000);
      idle(20);

      // Stop on the wrap cycle, then restart.
      step(0, 1, 0, 0);
      run_to_prewrap(100);
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      idle(5);

      // Pause on the wrap cycle, then resume.
      run_to_prewrap(100);
      step(0, 0, 1, 0);
      idle(5);
      step(0, 0, 1, 0);
      idle(3);

      // Reset mid-run, then pause/stop ignored in idle.
      run_until_t(7, 1000);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 1);
      idle(5);

      // Random pulses, at most one per cycle.
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 999));
         if (r < 3)       step(1, 0, 0, 0);
         else if (r < 23) step(0, 1, 0, 0);
         else if (r < 53) step(0, 0, 1, 0);
         else if (r < 63) step(0, 0, 0, 1);
         else             step(0, 0, 0, 0);
      end

      @(posedge clk);
      #3;
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0",
                  q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
